// File: rtl/operand_stack.sv
// operand_stack: parametrised LIFO operand stack for the calculator input path.
// Pushed words are zero-extended from IN_W to DATA_W. Pops land on a registered
// dout with a one-cycle dout_valid strobe. A push and a pop in the same cycle
// replace the top entry and return the old top.
//
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   push, pop, din  stack operations and push data
//   err_clr         clears sticky error flags
//   dout/dout_valid last popped word and its update strobe
//   count           occupancy 0..DEPTH
//   empty/full/have_data  decodes of count
//   overflow_err/underflow_err  sticky refusal flags
//
// Optional feature: define OPSTK_ERR_FLAGS_EN to enable the sticky error flags.
// Without it, both flags are tied low and err_clr is ignored.
module operand_stack #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned IN_W   = 16,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic              pop,
  input  logic [IN_W-1:0]   din,
  input  logic              err_clr,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  output logic [CNT_W-1:0]  count,
  output logic              empty,
  output logic              full,
  output logic              have_data,
  output logic              overflow_err,
  output logic              underflow_err
);

  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];

  logic [CNT_W-1:0] cnt_nxt;
  logic [IDX_W-1:0] top_idx;
  logic [IDX_W-1:0] wr_idx;
  logic             wr_en;
  logic             rd_en;
  logic             ovf_evt;
  logic             udf_evt;

  // Flag decodes of the registered count.
  assign empty     = (count == '0);
  assign full      = (count == FULL_CNT);
  assign have_data = !empty;

  // Top entry index; only used when the stack holds data.
  assign top_idx = IDX_W'(count - CNT_W'(1));

  // Per-cycle operation decode from sampled count.
  always_comb begin
    cnt_nxt = count;
    wr_en   = 1'b0;
    wr_idx  = '0;
    rd_en   = 1'b0;
    ovf_evt = 1'b0;
    udf_evt = 1'b0;
    if (push && pop) begin
      if (!empty) begin
        // Replace-top: old top goes out, new word takes its slot.
        wr_en  = 1'b1;
        wr_idx = top_idx;
        rd_en  = 1'b1;
      end else begin
        // Pop has nothing to return, the push still goes in.
        wr_en   = 1'b1;
        wr_idx  = '0;
        cnt_nxt = CNT_W'(1);
        udf_evt = 1'b1;
      end
    end else if (push) begin
      if (!full) begin
        wr_en   = 1'b1;
        wr_idx  = IDX_W'(count);
        cnt_nxt = count + CNT_W'(1);
      end else begin
        ovf_evt = 1'b1;
      end
    end else if (pop) begin
      if (!empty) begin
        rd_en   = 1'b1;
        cnt_nxt = count - CNT_W'(1);
      end else begin
        udf_evt = 1'b1;
      end
    end
  end

  // Storage array; intentionally not cleared by reset.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) begin
      mem[wr_idx] <= DATA_W'(din);
    end
  end

  // Occupancy and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count      <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
    end else begin
      count      <= cnt_nxt;
      dout_valid <= rd_en;
      if (rd_en) begin
        dout <= mem[top_idx];
      end
    end
  end

`ifdef OPSTK_ERR_FLAGS_EN
  // Sticky error flags; a same-cycle event beats err_clr.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      if (ovf_evt) begin
        overflow_err <= 1'b1;
      end else if (err_clr) begin
        overflow_err <= 1'b0;
      end
      if (udf_evt) begin
        underflow_err <= 1'b1;
      end else if (err_clr) begin
        underflow_err <= 1'b0;
      end
    end
  end
`else
  logic unused_err_sigs;
  assign unused_err_sigs = ^{err_clr, ovf_evt, udf_evt};
  assign overflow_err    = 1'b0;
  assign underflow_err   = 1'b0;
`endif

endmodule
